// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using the double-dabble algorithm:
// one shift-and-adjust iteration per clock, WIDTH iterations per conversion.
module bin2bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                valid,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow
);

  localparam int                BCD_W    = 4 * DIGITS;
  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   op_q;
  logic [BCD_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sticky_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;
  logic               busy_q;
  logic               valid_q;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   acc_d;
  logic [WIDTH-1:0]   op_d;
  logic               carry_out;
  logic               sticky_d;

  // NOTE: every combinational output gets a default before the loop so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // The bit leaving the top digit is a decimal carry past the last digit,
  // so the accumulator holds the operand modulo 10^DIGITS.
  assign carry_out = adj[BCD_W-1];
  assign sticky_d  = sticky_q | carry_out;
  assign acc_d     = {adj[BCD_W-2:0], op_q[WIDTH-1]};
  assign op_d      = {op_q[WIDTH-2:0], 1'b0};

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          valid_q <= 1'b0;
          if (start) begin
            op_q     <= bin;
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end else begin
            state_q  <= IDLE;
          end
        end
        SHIFT: begin
          acc_q    <= acc_d;
          op_q     <= op_d;
          cnt_q    <= cnt_q + 1'b1;
          sticky_q <= sticky_d;
          if (cnt_q == LAST_CNT) begin
            bcd_q   <= acc_d;
            ovf_q   <= sticky_d;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: binary input width, legal range 4..64.
REQ-002 The block SHALL have parameter DIGITS, default 10: number of BCD output digits, legal range 1..20.
REQ-003 The block SHALL have port clk  input  1: single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start  input  1: request to convert bin.
REQ-006 The block SHALL have port bin  input  WIDTH: unsigned binary operand, sampled only when start is accepted.
REQ-007 The block SHALL have port busy  output  1: high while a conversion is in progress.
REQ-008 The block SHALL have port valid  output  1: one-cycle pulse marking a completed conversion.
REQ-009 The block SHALL have port bcd  output  4*DIGITS: packed BCD result, with digit 0 (units) in bits [3:0].
REQ-010 The block SHALL have port overflow  output  1: high when the operand exceeded 10^DIGITS-1; qualified by valid.

Function
REQ-011 The block SHALL implement a three-state machine: IDLE, SHIFT, DONE.
REQ-012 In IDLE or DONE with start=1, the block SHALL accept the request: capture bin, clear the BCD accumulator and sticky overflow, zero the iteration counter, and go to SHIFT.
REQ-013 In DONE with start=0, the block SHALL go to IDLE; in IDLE with start=0, it SHALL stay in IDLE.
REQ-014 Each SHIFT cycle SHALL perform one double-dabble iteration.
  - Add 3 to every accumulator digit that is >=5.
  - Shift {accumulator, operand} left by one, so the operand MSB enters accumulator bit 0.
  - Increment the counter.
REQ-015 The block SHALL leave SHIFT for DONE on the edge that completes iteration WIDTH; there are exactly WIDTH iterations.
REQ-016 valid SHALL be high for exactly the one cycle spent in DONE, i.e. WIDTH+1 rising edges after the edge that accepted start.
REQ-017 busy SHALL be high exactly while in SHIFT.
REQ-018 start while busy=1 SHALL be ignored with no effect on the conversion in flight.
REQ-019 bcd and overflow SHALL update only on entry to DONE and hold their values until the next entry to DONE.
REQ-020 start asserted in DONE SHALL be accepted, giving back-to-back throughput of one result per WIDTH+1 cycles; valid is still high for that DONE cycle.
REQ-021 overflow SHALL be set if any 1 is shifted out of accumulator bit 4*DIGITS-1 during the conversion.
  - When overflow=1, bcd SHALL equal the operand modulo 10^DIGITS.
REQ-022 Every digit of bcd SHALL be in the range 0..9 for all inputs.
REQ-023 bin changes outside the accept cycle SHALL have no effect.

Reset
REQ-024 On rst_n=0, at any time and independent of clk, the block SHALL immediately set:
  - state to IDLE
  - busy=0, valid=0, overflow=0
  - bcd=0, accumulator=0, counter=0
REQ-025 Reset during SHIFT SHALL abort the conversion, and no valid pulse SHALL follow for it.
REQ-026 After rst_n rises, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-027 Defaults: bin=99, 46, 53, each as a one-cycle start pulse -> valid exactly 33 cycles after the accepting edge, with:
  - 99 -> bcd=0x0000000099
  - 46 -> bcd=0x0000000046
  - 53 -> bcd=0x0000000053
  - overflow=0 in all three cases.
REQ-028 Defaults: bin=32'hFFFFFFFF -> bcd=0x4294967295, overflow=0; bin=0 -> bcd=0, overflow=0.
REQ-029 WIDTH=8, DIGITS=2: bin=255 -> bcd=0x55, overflow=1; bin=99 -> bcd=0x99, overflow=0; latency 9 cycles.
REQ-030 Defaults: start with bin=46, then start with bin=53 at cycle 10 while busy -> single valid with bcd=0x46; no second valid.
REQ-031 Defaults: start held high continuously with bin=53 -> valid pulses every 33 cycles, each with bcd=0x53.
REQ-032 Defaults: start with bin=99, rst_n=0 asynchronously at cycle 15 -> busy and valid drop to 0 immediately and bcd=0; after release, start with bin=46 -> bcd=0x46.
